// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb
// Multi-port register file with a pending scoreboard for long-latency results.
//
// Decode reads operands through NRD combinational read ports and claims
// destination registers of long-latency ops. Writeback uses two write ports:
// port A (ALU/short-latency results) and port B (memory/long-latency results).
// A port-B write also retires the pending bit of its register.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   rd_en/rd_addr       per-port read enable and packed addresses (AW bits each)
//   rd_data/rd_busy     per-port read data (XLEN bits each) and busy flag
//   wa_en/addr/data     write port A
//   wb_en/addr/data     write port B; clears the pending bit
//   claim_en/addr       marks a register pending
//   pend_cnt            number of pending registers
//   err                 sticky protocol-error flag
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  output logic [AW:0]         pend_cnt,
  output logic                err
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_q, err_d;

  // Register 0 is hardwired zero, so every event aimed at it is dropped here.
  logic wa_hit, wb_hit, cl_hit;
  assign wa_hit = wa_en    && (wa_addr    != '0);
  assign wb_hit = wb_en    && (wb_addr    != '0);
  assign cl_hit = claim_en && (claim_addr != '0);

  // A claim on the same register as a port-B writeback overrides the clear.
  logic cl_wb_same;
  assign cl_wb_same = cl_hit && wb_hit && (claim_addr == wb_addr);

  logic cnt_inc, cnt_dec;
  assign cnt_inc = cl_hit && !pend_q[claim_addr];
  assign cnt_dec = wb_hit && pend_q[wb_addr] && !cl_wb_same;

  always_comb begin
    regs_d = regs_q;
    // NOTE: port A is assigned after port B so that, in this blocking-assignment
    // combinational block, the later write wins on a same-address collision.
    if (wb_hit) regs_d[wb_addr] = wb_data;
    if (wa_hit) regs_d[wa_addr] = wa_data;
  end

  always_comb begin
    pend_d = pend_q;
    if (wb_hit) pend_d[wb_addr]    = 1'b0;
    if (cl_hit) pend_d[claim_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
  end

  always_comb begin
    err_d = err_q;
    // Unexpected writeback: nothing outstanding for this register.
    if (wb_hit && !pend_q[wb_addr]) err_d = 1'b1;
    // Double claim, unless this cycle's writeback retires the earlier one.
    if (cl_hit && pend_q[claim_addr] && !cl_wb_same) err_d = 1'b1;
    // WAW hazard: judged after this cycle's port-B retirement, so a
    // port-A write racing the long-latency result it supersedes is legal.
    if (wa_hit && pend_q[wa_addr] && !(wb_hit && wb_addr == wa_addr)) err_d = 1'b1;
  end

  // NOTE: the register array is reset explicitly because software-visible
  // state must read as zero after rst; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Read ports: zero latency, disabled ports and register 0 return 0/not busy.
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (rd_en[i] && (ra != '0)) begin
        if (BYPASS != 0) begin
          if (wa_hit && wa_addr == ra)      rd_data[i*XLEN +: XLEN] = wa_data;
          else if (wb_hit && wb_addr == ra) rd_data[i*XLEN +: XLEN] = wb_data;
          else                              rd_data[i*XLEN +: XLEN] = regs_q[ra];
          // Busy reflects this cycle's retirement but not this cycle's claim.
          rd_busy[i] = pend_q[ra] && !(wb_hit && wb_addr == ra);
        end else begin
          rd_data[i*XLEN +: XLEN] = regs_q[ra];
          rd_busy[i]              = pend_q[ra];
        end
      end
    end
  end

  assign pend_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed testbench for regfile_mp_sb: a BYPASS=1 and a BYPASS=0 instance
// share all stimulus, so their architectural state stays identical.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data0;
  logic [NRD-1:0]      rd_busy, rd_busy0;
  logic                wa_en, wb_en, claim_en;
  logic [AW-1:0]       wa_addr, wb_addr, claim_addr;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic [AW:0]         pend_cnt, pend_cnt0;
  logic                err, err0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .pend_cnt(pend_cnt), .err(err)
  );

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .pend_cnt(pend_cnt0), .err(err0)
  );

  typedef struct {
    string           name;
    logic            wa_en;
    logic [AW-1:0]   wa_addr;
    logic [XLEN-1:0] wa_data;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            cl_en;
    logic [AW-1:0]   cl_addr;
    logic [1:0]      rd_en;
    logic [AW-1:0]   ra0, ra1;
    logic [XLEN-1:0] e_rd0, e_rd1;   // read data before the edge (BYPASS=1)
    logic [1:0]      e_busy;         // {port1, port0} before the edge
    logic [AW:0]     e_cnt;          // pend_cnt after the edge
    logic            e_err;          // err after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic wae, input logic [AW-1:0] waa,
                     input logic [XLEN-1:0] wad, input logic wbe, input logic [AW-1:0] wba,
                     input logic [XLEN-1:0] wbd, input logic cle, input logic [AW-1:0] cla,
                     input logic [1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1,
                     input logic [1:0] eb, input logic [AW:0] ec, input logic ee);
    vec_t v;
    v.name = n; v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd; v.cl_en = cle; v.cl_addr = cla;
    v.rd_en = re; v.ra0 = a0; v.ra1 = a1; v.e_rd0 = e0; v.e_rd1 = e1;
    v.e_busy = eb; v.e_cnt = ec; v.e_err = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wae, input logic [AW-1:0] waa, input logic [XLEN-1:0] wad,
                       input logic wbe, input logic [AW-1:0] wba, input logic [XLEN-1:0] wbd,
                       input logic cle, input logic [AW-1:0] cla,
                       input logic [1:0] re, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wa_en = wae; wa_addr = waa; wa_data = wad;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    claim_en = cle; claim_addr = cla;
    rd_en = re; rd_addr = {a1, a0};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // One cycle: drive at the falling edge, check reads, clock, check state.
  task automatic step();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    check("reset_cnt", 64'(pend_cnt), 0);
    check("reset_err", 64'(err), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 5, 7);
    #1;
    check("reset_rd", 64'(rd_data), 0);
    @(negedge clk);
    rst = 1'b0;

    //   name           wa: en addr data       wb: en addr data     cl: en addr  rd_en a0 a1  e_rd0         e_rd1         busy  cnt err
    add("wa_x5",          1, 5, 32'hDEADBEEF,  0, 0, 0,             0, 0,  2'b11, 5, 0, 32'hDEADBEEF, 0,            2'b00, 0, 0);
    add("wa_x0_rd_x5",    1, 0, 32'h1234,      0, 0, 0,             0, 0,  2'b11, 0, 5, 0,            32'hDEADBEEF, 2'b00, 0, 0);
    add("rd_x0",          0, 0, 0,             0, 0, 0,             0, 0,  2'b11, 0, 5, 0,            32'hDEADBEEF, 2'b00, 0, 0);
    add("claim_x7",       0, 0, 0,             0, 0, 0,             1, 7,  2'b11, 7, 5, 0,            32'hDEADBEEF, 2'b00, 1, 0);
    add("wa_wb_x7",       1, 7, 32'h11,        1, 7, 32'h22,        0, 0,  2'b11, 7, 7, 32'h11,       32'h11,       2'b00, 0, 0);
    add("rd_x7",          0, 0, 0,             0, 0, 0,             0, 0,  2'b11, 7, 3, 32'h11,       0,            2'b00, 0, 0);
    add("claim_x3",       0, 0, 0,             0, 0, 0,             1, 3,  2'b11, 3, 0, 0,            0,            2'b00, 1, 0);
    add("busy_x3",        0, 0, 0,             0, 0, 0,             0, 0,  2'b11, 3, 7, 0,            32'h11,       2'b01, 1, 0);
    add("claim_wb_x3",    0, 0, 0,             1, 3, 32'hAA,        1, 3,  2'b11, 3, 3, 32'hAA,       32'hAA,       2'b00, 1, 0);
    add("x3_still_pend",  0, 0, 0,             0, 0, 0,             0, 0,  2'b11, 3, 0, 32'hAA,       0,            2'b01, 1, 0);
    add("wb_x3",          0, 0, 0,             1, 3, 32'hBB,        0, 0,  2'b11, 3, 0, 32'hBB,       0,            2'b00, 0, 0);
    add("claim_x1",       0, 0, 0,             0, 0, 0,             1, 1,  2'b11, 1, 3, 0,            32'hBB,       2'b00, 1, 0);
    add("claim_x2",       0, 0, 0,             0, 0, 0,             1, 2,  2'b11, 1, 2, 0,            0,            2'b01, 2, 0);
    add("claim_x4",       0, 0, 0,             0, 0, 0,             1, 4,  2'b11, 2, 4, 0,            0,            2'b01, 3, 0);
    add("claim9_wb1",     0, 0, 0,             1, 1, 32'h101,       1, 9,  2'b11, 1, 9, 32'h101,      0,            2'b00, 3, 0);
    add("wb_x2",          0, 0, 0,             1, 2, 32'h202,       0, 0,  2'b11, 9, 2, 0,            32'h202,      2'b01, 2, 0);
    add("wb_x4",          0, 0, 0,             1, 4, 32'h404,       0, 0,  2'b11, 4, 9, 32'h404,      0,            2'b10, 1, 0);
    add("wb_x9",          0, 0, 0,             1, 9, 32'h909,       0, 0,  2'b11, 9, 4, 32'h909,      32'h404,      2'b00, 0, 0);
    add("wb_x6_unexp",    0, 0, 0,             1, 6, 32'h66,        0, 0,  2'b11, 6, 0, 32'h66,       0,            2'b00, 0, 1);
    add("err_hold_wa",    1, 10, 32'hA,        0, 0, 0,             0, 0,  2'b01, 6, 10, 32'h66,      0,            2'b00, 0, 1);
    add("err_hold_cl",    0, 0, 0,             0, 0, 0,             1, 11, 2'b10, 11, 6, 0,           32'h66,       2'b00, 1, 1);
    add("err_hold_wb",    0, 0, 0,             1, 11, 32'hB,        0, 0,  2'b11, 11, 10, 32'hB,      32'hA,        2'b00, 0, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].wa_en, vecs[k].wa_addr, vecs[k].wa_data, vecs[k].wb_en, vecs[k].wb_addr,
            vecs[k].wb_data, vecs[k].cl_en, vecs[k].cl_addr, vecs[k].rd_en, vecs[k].ra0, vecs[k].ra1);
      #1;
      check({vecs[k].name, "_rd0"},  64'(rd_data[0 +: XLEN]),    64'(vecs[k].e_rd0));
      check({vecs[k].name, "_rd1"},  64'(rd_data[XLEN +: XLEN]), 64'(vecs[k].e_rd1));
      check({vecs[k].name, "_busy"}, 64'(rd_busy),              64'(vecs[k].e_busy));
      @(posedge clk);
      #1;
      check({vecs[k].name, "_cnt"},  64'(pend_cnt),  64'(vecs[k].e_cnt));
      check({vecs[k].name, "_err"},  64'(err),       64'(vecs[k].e_err));
      check({vecs[k].name, "_cnt0"}, 64'(pend_cnt0), 64'(vecs[k].e_cnt));
      @(negedge clk);
    end

    // Asynchronous reset mid-operation: x8 pending, a port-A write in flight.
    drive(0, 0, 0, 0, 0, 0, 1, 8, 2'b00, 0, 0);
    step();
    check("pre_rst_cnt", 64'(pend_cnt), 1);
    drive(1, 12, 32'h1212, 0, 0, 0, 0, 0, 2'b11, 8, 6);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_cnt",  64'(pend_cnt), 0);
    check("rst_async_err",  64'(err), 0);
    check("rst_async_rd",   64'(rd_data), 0);
    check("rst_async_busy", 64'(rd_busy), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 12, 8);
    #1;
    check("rst_wa_lost", 64'(rd_data), 0);
    check("rst_x8_busy", 64'(rd_busy), 0);

    // Case 2 again, comparing the BYPASS=0 view with the BYPASS=1 view.
    drive(1, 7, 32'h55, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 2'b00, 0, 0);
    step();
    drive(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 2'b11, 7, 7);
    #1;
    check("nobyp_rd",   64'(rd_data0), {32'h55, 32'h55});
    check("nobyp_busy", 64'(rd_busy0), 2'b11);
    check("byp_rd",     64'(rd_data),  {32'h11, 32'h11});
    check("byp_busy",   64'(rd_busy),  2'b00);
    @(posedge clk);
    #1;
    check("nobyp_cnt", 64'(pend_cnt0), 0);
    check("nobyp_err", 64'(err0), 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 7, 0);
    #1;
    check("nobyp_after", 64'(rd_data0[0 +: XLEN]), 32'h11);

    // WAW hazard: port-A write to a pending register with no retirement.
    drive(0, 0, 0, 0, 0, 0, 1, 13, 2'b00, 0, 0);
    step();
    check("waw_pre_err", 64'(err), 0);
    drive(1, 13, 32'h1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    step();
    check("waw_err", 64'(err), 1);

    // Double claim without retirement.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 14, 2'b00, 0, 0);
    step();
    check("dclaim_pre_err", 64'(err), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 14, 2'b00, 0, 0);
    step();
    check("dclaim_err", 64'(err), 1);
    check("dclaim_cnt", 64'(pend_cnt), 1);

    // Register 0 events: ignored, no error, no count change.
    do_reset();
    drive(1, 0, 32'h5, 1, 0, 32'h6, 1, 0, 2'b11, 0, 0);
    #1;
    check("x0_rd", 64'(rd_data), 0);
    step();
    check("x0_cnt", 64'(pend_cnt), 0);
    check("x0_err", 64'(err), 0);

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
